// File: rtl/bs_line_buffer.sv
// bs_line_buffer: single-line delay buffer feeding the bilinear scaler.
// For every active input pixel it emits the current pixel and the pixel in
// the same column of the previous active line (vertical tap pair), plus the
// pixel coordinates and line markers, all with a fixed 2-cycle latency.
//
// Ports
//   clk           720p pixel clock
//   rst           synchronous active-high reset
//   sync_i[2:0]   {VS, HS, DE}, active-high
//   data_i        input pixel, valid when DE=1
//   sync_o        sync_i delayed 2 cycles
//   cur_o         current pixel (0 outside DE)
//   prev_o        same-column pixel of the previous active line (0 outside DE)
//   x_o           column of cur_o (0 outside DE)
//   y_o           active line index of cur_o within the frame
//   first_line_o  high on active output pixels of line 0
//   line_done_o   one-cycle pulse on the first output cycle after DE drops
//   overflow_o    sticky: some line carried more than MAX_WIDTH pixels
//
// Build option
//   BS_LINE_BUFFER_EDGE_REPLICATE_EN: on first-line and overflow pixels,
//   prev_o repeats cur_o instead of returning 0 (no black top row).
module bs_line_buffer #(
  parameter int DATA_W    = 24,
  parameter int MAX_WIDTH = 1280,
  parameter int ADDR_W    = 11,
  parameter int Y_W       = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        sync_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [2:0]        sync_o,
  output logic [DATA_W-1:0] cur_o,
  output logic [DATA_W-1:0] prev_o,
  output logic [ADDR_W-1:0] x_o,
  output logic [Y_W-1:0]    y_o,
  output logic              first_line_o,
  output logic              line_done_o,
  output logic              overflow_o
);

  localparam int LAT = 2;
  // One extra bit so MAX_WIDTH == 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] X_LIM = (ADDR_W+1)'(MAX_WIDTH);

  typedef struct packed {
    logic [1:0]        hv;     // {VS, HS}
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] x;
    logic [Y_W-1:0]    y;
    logic              first;  // pixel belongs to line 0
    logic              ovf;    // active pixel beyond RAM depth
  } stage_t;

  // ---------------- input side: counters and edge detect ----------------
  logic              de, vs_rise, de_fall, in_range, ram_we;
  logic              de_d, vs_d;
  logic [ADDR_W-1:0] x_cnt;
  logic [Y_W-1:0]    y_cnt;

  assign de       = sync_i[0];
  assign vs_rise  = sync_i[2] & ~vs_d;
  assign de_fall  = de_d & ~de;
  assign in_range = {1'b0, x_cnt} < X_LIM;
  assign ram_we   = de & in_range & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
      de_d  <= 1'b0;
      vs_d  <= 1'b0;
    end else begin
      de_d <= de;
      vs_d <= sync_i[2];
      // x saturates rather than wrapping so overlong lines stay out of range.
      if (de) begin
        if (x_cnt != '1) x_cnt <= x_cnt + 1'b1;
      end else begin
        x_cnt <= '0;
      end
      // VS clear has priority over a coincident end-of-line increment.
      if (vs_rise)                       y_cnt <= '0;
      else if (de_fall && y_cnt != '1)   y_cnt <= y_cnt + 1'b1;
    end
  end

  // ---------------- line RAM (read-first, not reset) ----------------
  logic [DATA_W-1:0] mem [MAX_WIDTH];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      rd_q       <= mem[x_cnt];   // old content: the previous line's pixel
      mem[x_cnt] <= data_i;
    end
  end

  // ---------------- stage 1: align with RAM read data ----------------
  logic [LAT:1] vld_pipe;
  stage_t       s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-1:1], de};
      s1.hv    <= sync_i[2:1];
      s1.data  <= data_i;
      s1.x     <= x_cnt;
      s1.y     <= y_cnt;
      s1.first <= (y_cnt == '0);
      s1.ovf   <= de & ~in_range;
    end
  end

  // ---------------- stage 2: registered outputs ----------------
  logic              de1;
  logic [DATA_W-1:0] fill, prev_sel;
  logic [1:0]        hv_o;

  assign de1 = vld_pipe[1];

`ifdef BS_LINE_BUFFER_EDGE_REPLICATE_EN
  assign fill = s1.data;
`else
  assign fill = '0;
`endif

  // No valid previous line on line 0 or past the RAM depth.
  assign prev_sel = (s1.first | s1.ovf) ? fill : rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hv_o         <= '0;
      cur_o        <= '0;
      prev_o       <= '0;
      x_o          <= '0;
      y_o          <= '0;
      first_line_o <= 1'b0;
      line_done_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      hv_o         <= s1.hv;
      cur_o        <= de1 ? s1.data : '0;
      prev_o       <= de1 ? prev_sel : '0;
      x_o          <= de1 ? s1.x : '0;
      y_o          <= s1.y;
      first_line_o <= de1 & s1.first;
      line_done_o  <= vld_pipe[LAT] & ~de1;
      overflow_o   <= overflow_o | (de1 & s1.ovf);
    end
  end

  assign sync_o = {hv_o, vld_pipe[LAT]};

endmodule

// File: doc/bs_line_buffer.md
Name: bs_line_buffer

Overview:
- Single-line delay buffer between the 720p source stream and the bilinear scaler (BS).
- Runs in the 720p pixel clock domain.
- For every active input pixel it outputs two pixels: the current pixel, and the pixel in the same column of the previous active line. These are the vertical tap pair the interpolator needs.
- Also outputs pixel coordinates and line/frame markers, all aligned to the delayed stream.

Parameters:
- DATA_W, 24, RGB pixel width.
- MAX_WIDTH, 1280, maximum stored active pixels per line (RAM depth).
- ADDR_W, 11, column counter / RAM address width; must satisfy 2^ADDR_W >= MAX_WIDTH.
- Y_W, 11, line counter width.

Ports:
- clk  input  1  pixel clock (720p domain).
- rst  input  1  synchronous, active-high reset.
- sync_i  input  3  {VS, HS, DE}: bit2 VS, bit1 HS, bit0 DE; all active-high.
- data_i  input  DATA_W  input pixel; valid when sync_i[0]=1.
- sync_o  output  3  sync_i delayed exactly 2 cycles.
- cur_o  output  DATA_W  data_i delayed 2 cycles; 0 when sync_o[0]=0.
- prev_o  output  DATA_W  same-column pixel of previous active line; 0 when sync_o[0]=0.
- x_o  output  ADDR_W  column of cur_o (0-based); 0 when sync_o[0]=0.
- y_o  output  Y_W  active line index of cur_o within the frame.
- first_line_o  output  1  high while y_o==0 and sync_o[0]=1.
- line_done_o  output  1  one-cycle pulse on the first output cycle with sync_o[0]=0 after a cycle with sync_o[0]=1.
- overflow_o  output  1  sticky flag: a line exceeded MAX_WIDTH pixels.

Behaviour:
- Reset values: every output 0; internal x/y counters 0; edge-detect registers 0. RAM contents are not reset.
- Fixed latency: 2 cycles on every output path, independent of content.
- Column counter x:
  - Increments on each input cycle with DE=1.
  - Clears to 0 on the cycle after DE falls.
  - Holds at 2^ADDR_W-1; no wrap.
- RAM, on each DE=1 cycle with x < MAX_WIDTH:
  - Read address x and write data_i to address x in the same cycle.
  - Read-first: the read returns the previous line's value, never the new one.
  - Read data is registered once; cur/sync/x/y paths are pipelined to match the 2-cycle latency.
- Overflow, on a DE=1 cycle with x >= MAX_WIDTH:
  - No RAM write.
  - prev_o for that pixel is 0.
  - overflow_o sets and stays set until rst.
- Line counter y:
  - Increments by 1 on each DE falling edge (input side).
  - Saturates at 2^Y_W-1.
  - Clears to 0 on each VS rising edge.
- Simultaneous DE falling edge and VS rising edge: the clear wins, so y=0.
- VS rising while DE=1 clears y only; x keeps counting.
- First line (y==0): prev_o=0 for every pixel (default build). RAM is still written, so line 1 sees line 0.
- Line shorter than the previous one: only addresses 0..len-1 are rewritten. Stale tail entries are never read on that line.
- Line longer than the previous one (up to MAX_WIDTH): prev_o for columns beyond the previous length returns stale RAM data. This is allowed and unspecified.
- Reset mid-frame: y restarts at 0 on the next line, and that line is treated as a first line until the next VS rising edge.
- HS is only delayed; it has no effect on counters.

Optional Feature:
- Macro: BS_LINE_BUFFER_EDGE_REPLICATE_EN.
- Defined: on first-line pixels, and on overflow pixels, prev_o equals cur_o (edge replication). This removes the black top row in scaler output.
- Undefined: prev_o=0 in those cases, as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=1 for 3 cycles with DE toggling -> all outputs 0. After release, first DE=1 pixel appears on sync_o[0] exactly 2 cycles later.
- Two lines:
  - Stimulus: VS pulse, then line 0 with data = x (0..1279), 370 blanking cycles, then line 1 with data = 0x100000+x.
  - Line 1 response: prev_o = x and cur_o = 0x100000+x at x_o = x, with y_o=1.
  - Line 0 response: prev_o=0 and first_line_o=1.
  - line_done_o pulses exactly twice.
- Overflow: a 1300-pixel line with MAX_WIDTH=1280 -> overflow_o rises at x_o=1280 and stays set; prev_o=0 for x_o 1280..1299; next line columns 0..1279 match.
- Frame wrap: 720 lines, then VS, then a new line -> y_o returns to 0 and first_line_o=1. Also drive DE fall and VS rise in the same cycle -> y_o=0 on the next line.
- Edge replicate (macro defined): two-line test -> on line 0 prev_o == cur_o for all 1280 pixels; line 1 is unchanged from the default build.
- Full 720p timing (1650x750, 1280x720 active) for 2 frames -> y_o maximum 719, 720 line_done_o pulses per frame, no overflow.
